// File: rtl/fa32_result_fifo.sv
// First-word-fall-through result FIFO capturing {cout, sum} from the 32-bit adder.
// Optional sticky overflow flag built only when FA32_RESULT_FIFO_OVF_EN is defined.
module fa32_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_sum,
    input  logic                     in_cout,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_cout,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);

    // Handshakes: a word moves on a rising edge only when its valid and ready
    // are both high at that edge. in_ready and out_valid come from registered
    // pointers alone, so neither side sees a combinational path from the other.
    logic [WIDTH:0] r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_wr_en;
    logic           w_rd_en;
    logic [WIDTH:0] w_head;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign w_wr_en = in_valid && !full;
    assign w_rd_en = out_valid && out_ready;

    assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
    assign out_sum  = w_head[WIDTH-1:0];
    assign out_cout = w_head[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left out of reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {in_cout, in_sum};
    end

`ifdef FA32_RESULT_FIFO_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid && full) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fa32_result_fifo.sv
// Randomized and directed bench for fa32_result_fifo against a queue-based model.
// Honors FA32_RESULT_FIFO_OVF_EN when predicting the overflow flag.
module tb_fa32_result_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_sum = '0;
    logic             in_cout = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ready = 1'b0;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             ovf;

    fa32_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf)
    );

    // scoreboard: expected FIFO contents {cout, sum}, head at index 0
    logic [WIDTH:0] exp_q[$];
    logic           exp_ovf = 1'b0;
    int             n_checks = 0;
    int             n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where);
        int sz;
        sz = exp_q.size();
        check_eq({where, ".count"}, 64'(count), 64'(sz));
        check_eq({where, ".full"}, 64'(full), 64'(sz == DEPTH));
        check_eq({where, ".empty"}, 64'(empty), 64'(sz == 0));
        check_eq({where, ".in_ready"}, 64'(in_ready), 64'(sz != DEPTH));
        check_eq({where, ".out_valid"}, 64'(out_valid), 64'(sz != 0));
        check_eq({where, ".ovf"}, 64'(ovf), 64'(exp_ovf));
        if (sz > 0) begin
            check_eq({where, ".out_sum"}, 64'(out_sum), 64'(exp_q[0][WIDTH-1:0]));
            check_eq({where, ".out_cout"}, 64'(out_cout), 64'(exp_q[0][WIDTH]));
        end
    endtask

    // driver: called at a falling edge; applies inputs, predicts, checks after the edge
    task automatic step(input logic v, input logic [WIDTH-1:0] s, input logic c,
                        input logic r, input string where);
        int sz;
        logic do_rd;
        logic do_wr;
        in_valid  = v;
        in_sum    = s;
        in_cout   = c;
        out_ready = r;
        sz    = exp_q.size();
        do_rd = r && (sz > 0);
        do_wr = v && (sz < DEPTH);
`ifdef FA32_RESULT_FIFO_OVF_EN
        if (v && sz == DEPTH) exp_ovf = 1'b1;
`endif
        if (do_rd) void'(exp_q.pop_front());
        if (do_wr) exp_q.push_back({c, s});
        @(posedge clk);
        @(negedge clk);
        check_outputs(where);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_sum    = '0;
        in_cout   = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic drain(input string where);
        while (exp_q.size() > 0) step(1'b0, '0, 1'b0, 1'b1, where);
    endtask

    initial begin
        int pv;
        int pr;

        // power-on reset
        repeat (3) @(negedge clk);
        check_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("post_por");

        // single word, held then consumed
        step(1'b1, 32'h0000_0005, 1'b0, 1'b0, "single_wr");
        step(1'b0, '0, 1'b0, 1'b0, "single_hold");
        step(1'b0, '0, 1'b0, 1'b1, "single_rd");

        // fill, overflow attempt, drain in order
        for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, "fill");
        drain("fill_drain");

        // carry path
        step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, "carry_wr");
        drain("carry_drain");

        // streaming across the pointer wrap
        for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b1, "stream");
        drain("stream_drain");

        // simultaneous read and write while full
        for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(32'hA0 + i), 1'b0, 1'b0, "full_fill");
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, "full_rw");
        check_eq("full_rw.count3", 64'(count), 64'd3);
        drain("full_rw_drain");

        // asynchronous reset mid-stream with three words stored
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(32'h30 + i), 1'b1, 1'b0, "pre_rst");
        check_eq("pre_rst.count", 64'(count), 64'd3);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst.empty", 64'(empty), 64'd1);
        check_eq("async_rst.count", 64'(count), 64'd0);
        check_eq("async_rst.out_valid", 64'(out_valid), 64'd0);
        check_eq("async_rst.in_ready", 64'(in_ready), 64'd1);
        check_eq("async_rst.full", 64'(full), 64'd0);
        check_eq("async_rst.ovf", 64'(ovf), 64'd0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs("post_rst");
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0, "first_after_rst");
        drain("first_after_rst_drain");

        // randomized traffic with shifting producer/consumer bias
        for (int ph = 0; ph < 6; ph++) begin
            pv = $urandom_range(20, 95);
            pr = $urandom_range(20, 95);
            for (int i = 0; i < 60; i++) begin
                step(1'($urandom_range(0, 99) < pv), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) < pr), "rand");
            end
        end
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
